// File: rtl/fib_pkg.sv
// Shared encodings for the Fibonacci controller and datapath.
// It holds the micro-op opcodes and the register-file index names.
package fib_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SETC = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_TEST = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_MOV  = 3'b111;

  localparam logic [1:0] R_CNT = 2'd0;
  localparam logic [1:0] R_A   = 2'd1;
  localparam logic [1:0] R_B   = 2'd2;
  localparam logic [1:0] R_TMP = 2'd3;

endpackage

// File: rtl/fib_alu.sv
// Combinational micro-op evaluator for one register-file write per cycle.
// We marks the ops that write rf[d]; carry is only meaningful for ADD.
module fib_alu
  import fib_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   opcode,
  input  logic         setc_bit,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] imm,
  output logic [W-1:0] y,
  output logic         carry,
  output logic         we
);

  always_comb begin
    y     = '0;
    carry = 1'b0;
    we    = 1'b0;
    case (opcode)
      OP_SETC: begin
        y  = {{(W-1){1'b0}}, setc_bit};
        we = 1'b1;
      end
      OP_DEC: begin
        y  = a - {{(W-1){1'b0}}, 1'b1};
        we = 1'b1;
      end
      OP_LOAD: begin
        y  = imm;
        we = 1'b1;
      end
      OP_ADD: begin
        {carry, y} = {1'b0, a} + {1'b0, b};
        we         = 1'b1;
      end
      OP_MOV: begin
        y  = b;
        we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fib_datapath.sv
// Register file, zero flag, overflow flag and result handshake driven by
// the Fibonacci controller's micro-ops.
module fib_datapath
  import fib_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [2:0]   opcode,
  input  logic [1:0]   operand1,
  input  logic [1:0]   operand2,
  input  logic         DONE,
  input  logic [W-1:0] N_IN,
  output logic         ZERO_FLAG,
  output logic [W-1:0] RESULT,
  output logic         RESULT_VALID,
  input  logic         RESULT_READY,
  output logic         OVF
);

  logic [3:0][W-1:0] rf;
  logic [W-1:0]      alu_y;
  logic              alu_carry;
  logic              alu_we;
  logic              done_q;
  logic              capture;

  fib_alu #(.W(W)) u_alu (
    .opcode   (opcode),
    .setc_bit (operand1[1]),
    .a        (rf[operand1]),
    .b        (rf[operand2]),
    .imm      (N_IN),
    .y        (alu_y),
    .carry    (alu_carry),
    .we       (alu_we)
  );

  // The controller branches on this in the same cycle it presents TEST.
  assign ZERO_FLAG = (opcode == OP_TEST) && (rf[operand1] == '0);
  assign capture   = DONE && !done_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rf <= '0;
    end else if (alu_we) begin
      rf[operand1] <= alu_y;
    end
  end

  // A LOAD of the loop counter marks the start of a new run.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OVF <= 1'b0;
    end else if (opcode == OP_LOAD && operand1 == R_CNT) begin
      OVF <= 1'b0;
    end else if (opcode == OP_ADD && alu_carry) begin
      OVF <= 1'b1;
    end
  end

  // Capture takes priority over a same-edge accept so a fresh result is never lost.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      done_q       <= 1'b0;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
    end else begin
      done_q <= DONE;
      if (capture) begin
        RESULT       <= rf[R_A];
        RESULT_VALID <= 1'b1;
      end else if (RESULT_VALID && RESULT_READY) begin
        RESULT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fib_datapath.sv
// Directed bench acting as the Fibonacci controller for fib_datapath.
module tb_fib_datapath;
  import fib_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [2:0]  opcode = OP_NOP;
  logic [1:0]  operand1 = 2'd0;
  logic [1:0]  operand2 = 2'd0;
  logic        DONE = 1'b0;
  logic [15:0] N_IN = '0;
  logic        ZERO_FLAG;
  logic [15:0] RESULT;
  logic        RESULT_VALID;
  logic        RESULT_READY = 1'b0;
  logic        OVF;

  int errors = 0;
  int checks = 0;

  fib_datapath #(.W(16)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .opcode       (opcode),
    .operand1     (operand1),
    .operand2     (operand2),
    .DONE         (DONE),
    .N_IN         (N_IN),
    .ZERO_FLAG    (ZERO_FLAG),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .RESULT_READY (RESULT_READY),
    .OVF          (OVF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s);
    opcode = o; operand1 = d; operand2 = s;
    tick();
  endtask

  // Controller sequence: a=0, b=1; each pass tmp=a+b, a=b, b=tmp, cnt--.
  // stop>=0 halts after that many passes; otherwise loop until TEST R0 is zero.
  task automatic run_fib(input logic [15:0] n, input int stop, output int iters);
    N_IN = n;
    do_op(OP_LOAD, R_CNT, R_CNT);
    do_op(OP_SETC, R_A, R_A);
    do_op(OP_SETC, R_B, R_B);
    iters = 0;
    for (int k = 0; k < 40; k++) begin
      if (stop >= 0 && iters == stop) break;
      opcode = OP_TEST; operand1 = R_CNT; #1;
      if (ZERO_FLAG) begin
        tick();
        break;
      end
      tick();
      do_op(OP_MOV, R_TMP, R_A);
      do_op(OP_ADD, R_TMP, R_B);
      do_op(OP_MOV, R_A, R_B);
      do_op(OP_MOV, R_B, R_TMP);
      do_op(OP_DEC, R_CNT, R_CNT);
      iters++;
    end
    opcode = OP_NOP;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; N_IN = 16'd7; opcode = OP_LOAD; operand1 = R_CNT;
    tick(); tick();
    checks++; if (RESULT !== 16'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", RESULT); end
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", RESULT_VALID); end
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", OVF); end
    RST_N = 1'b1; opcode = OP_TEST;
    for (int r = 0; r < 4; r++) begin
      operand1 = 2'(r); #1;
      checks++; if (ZERO_FLAG !== 1'b1) begin errors++; $display("FAIL reset_reg%0d_zero: zf=%b want 1", r, ZERO_FLAG); end
    end
    opcode = OP_NOP;
    tick();
  endtask

  task automatic test_zero_flag();
    N_IN = 16'd5;
    do_op(OP_LOAD, R_CNT, R_CNT);
    opcode = OP_TEST; operand1 = R_CNT; #1;
    checks++; if (ZERO_FLAG !== 1'b0) begin errors++; $display("FAIL zf_r0_5: got %b want 0", ZERO_FLAG); end
    tick();
    N_IN = 16'd0;
    do_op(OP_LOAD, R_CNT, R_CNT);
    opcode = OP_TEST; operand1 = R_CNT; #1;
    checks++; if (ZERO_FLAG !== 1'b1) begin errors++; $display("FAIL zf_r0_0: got %b want 1", ZERO_FLAG); end
    opcode = OP_ADD; operand2 = R_CNT; #1;
    checks++; if (ZERO_FLAG !== 1'b0) begin errors++; $display("FAIL zf_under_add: got %b want 0", ZERO_FLAG); end
    opcode = OP_NOP;
    tick();
  endtask

  task automatic test_n10_handshake();
    int it;
    run_fib(16'd10, -1, it);
    checks++; if (it !== 10) begin errors++; $display("FAIL n10_iters: got %0d want 10", it); end
    DONE = 1'b1; #1;
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL n10_valid_early: got %b want 0", RESULT_VALID); end
    tick();
    checks++; if (RESULT_VALID !== 1'b1) begin errors++; $display("FAIL n10_valid: got %b want 1", RESULT_VALID); end
    checks++; if (RESULT !== 16'd55) begin errors++; $display("FAIL n10_result: got %0d want 55", RESULT); end
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL n10_ovf: got %b want 0", OVF); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (RESULT !== 16'd55 || RESULT_VALID !== 1'b1) begin
        errors++; $display("FAIL hold_stable c%0d: result=%0d valid=%b want 55/1", c, RESULT, RESULT_VALID);
      end
    end
    RESULT_READY = 1'b1; tick(); RESULT_READY = 1'b0;
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL accept_clears: got %b want 0", RESULT_VALID); end
    tick();
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL done_held_no_recapture: got %b want 0", RESULT_VALID); end
    DONE = 1'b0; tick();
  endtask

  task automatic test_small_n();
    int it;
    run_fib(16'd1, -1, it);
    DONE = 1'b1; tick();
    checks++; if (RESULT !== 16'd1 || RESULT_VALID !== 1'b1) begin errors++; $display("FAIL n1_result: got %0d/%b want 1/1", RESULT, RESULT_VALID); end
    RESULT_READY = 1'b1; DONE = 1'b0; tick(); RESULT_READY = 1'b0;
    run_fib(16'd2, -1, it);
    DONE = 1'b1; tick();
    checks++; if (RESULT !== 16'd1 || RESULT_VALID !== 1'b1) begin errors++; $display("FAIL n2_result: got %0d/%b want 1/1", RESULT, RESULT_VALID); end
    RESULT_READY = 1'b1; DONE = 1'b0; tick(); RESULT_READY = 1'b0;
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL n2_consumed: got %b want 0", RESULT_VALID); end
  endtask

  task automatic test_overflow();
    int it;
    run_fib(16'd25, -1, it);
    DONE = 1'b1; tick();
    checks++; if (RESULT !== 16'd9489) begin errors++; $display("FAIL n25_result: got %0d want 9489", RESULT); end
    checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL n25_ovf: got %b want 1", OVF); end
    N_IN = 16'd3;
    do_op(OP_LOAD, R_CNT, R_CNT);
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL load_clears_ovf: got %b want 0", OVF); end
    checks++; if (RESULT !== 16'd9489 || RESULT_VALID !== 1'b1) begin errors++; $display("FAIL n25_pending: got %0d/%b want 9489/1", RESULT, RESULT_VALID); end
    DONE = 1'b0; do_op(OP_NOP, 2'd0, 2'd0);
  endtask

  task automatic test_back_to_back();
    int it;
    run_fib(16'd5, -1, it);
    DONE = 1'b1; RESULT_READY = 1'b1; tick(); RESULT_READY = 1'b0;
    checks++; if (RESULT !== 16'd5 || RESULT_VALID !== 1'b1) begin errors++; $display("FAIL capture_beats_accept: got %0d/%b want 5/1", RESULT, RESULT_VALID); end
    DONE = 1'b0; tick();
  endtask

  task automatic test_reset_mid_run();
    int it;
    run_fib(16'd10, 7, it);
    RST_N = 1'b0; tick(); RST_N = 1'b1;
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", RESULT_VALID); end
    checks++; if (RESULT !== 16'd0) begin errors++; $display("FAIL midreset_result: got %0d want 0", RESULT); end
    opcode = OP_TEST;
    for (int r = 0; r < 4; r++) begin
      operand1 = 2'(r); #1;
      checks++; if (ZERO_FLAG !== 1'b1) begin errors++; $display("FAIL midreset_reg%0d_zero: zf=%b want 1", r, ZERO_FLAG); end
    end
    opcode = OP_NOP; tick();
    run_fib(16'd6, -1, it);
    DONE = 1'b1; tick();
    checks++; if (RESULT !== 16'd8 || RESULT_VALID !== 1'b1) begin errors++; $display("FAIL restart_n6: got %0d/%b want 8/1", RESULT, RESULT_VALID); end
    DONE = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_zero_flag();
    test_n10_handshake();
    test_small_n();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
